spi_flash_reader: RTL

- Wishbone master that sequences the SoC SPI master peripheral to perform SPI-flash READ (0x03) transactions.
- Client issues start address and byte count. Block programs the divisor, asserts chip select, shifts command, address and dummy bytes, and streams received bytes out.
- Sits between the boot/DMA logic and the SPI master's Wishbone slave port. The SPI master register map is fixed:
  - 0x00: data; a write starts a transfer.
  - 0x04: status; bit0 = run.
  - 0x08: chip select.
  - 0x10: divisor.

---
 rtl/spi_flash_reader_pkg.sv | 34 +++
 rtl/spi_flash_reader_wb_master_port.sv | 64 ++++++
 rtl/spi_flash_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_pkg.sv
// rtl/spi_flash_reader_pkg.sv - shared types and constants for the SPI-flash reader
// Contents: FSM state enum, SPI master register offsets, READ opcode, header byte helper.
package spi_flash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_DIV,
        ST_CS_ON,
        ST_TX,
        ST_POLL,
        ST_RX,
        ST_PUSH,
        ST_CS_OFF,
        ST_DONE
    } state_e;

    localparam logic [31:0] REG_DATA = 32'h0000_0000;
    localparam logic [31:0] REG_STAT = 32'h0000_0004;
    localparam logic [31:0] REG_CS   = 32'h0000_0008;
    localparam logic [31:0] REG_DIV  = 32'h0000_0010;

    localparam logic [7:0] CMD_READ = 8'h03;

    // Header sequence: opcode, then the 24-bit address most significant byte first.
    function automatic logic [7:0] header_byte(input logic [1:0] hi, input logic [23:0] addr);
        case (hi)
            2'd0:    return CMD_READ;
            2'd1:    return addr[23:16];
            2'd2:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_reader_wb_master_port.sv
// rtl/spi_flash_reader_wb_master_port.sv - single-outstanding Wishbone master handshake
// Ports: clk, reset_n (async, active-low); go_i/we_i/adr_i/wdat_i request an access,
// busy_o is high while the cycle is open, ack_o pulses in the ack cycle with rdat_o valid;
// wbm_* is the Wishbone master bus.
module wb_master_port (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [7:0]  wdat_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [7:0]  rdat_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i
);

    logic        cyc_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [7:0]  dat_q;
    logic        unused_dat;

    // Address/data/we are captured at launch and held until ack; cyc drops on the
    // ack edge, so a new launch can only follow after one idle cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= 32'h0;
            dat_q <= 8'h0;
        end else if (cyc_q) begin
            if (wbm_ack_i) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
            end
        end else if (go_i) begin
            cyc_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= wdat_i;
        end
    end

    assign busy_o     = cyc_q;
    assign ack_o      = cyc_q & wbm_ack_i;
    assign rdat_o     = wbm_dat_i[7:0];
    assign unused_dat = ^wbm_dat_i[31:8];

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = {24'h0, dat_q};
    assign wbm_sel_o = 4'b1111;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - sequences an SPI master peripheral to perform flash READ (0x03)
// Ports: clk, reset_n (async, active-low); req_* start a read of req_len bytes at req_addr;
// rd_data/rd_valid/rd_ready stream received bytes; done pulses at the end with err on poll
// timeout; wbm_* drives the SPI master's Wishbone slave port.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter logic [7:0]  DIVISOR    = 8'h03,
    parameter logic [7:0]  CS_ACTIVE  = 8'hFE,
    parameter logic [7:0]  CS_IDLE    = 8'hFF,
    parameter int          POLL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic        err,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i
);

    localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);

    state_e      state_q;
    logic        req_ready_q;
    logic        go_q;
    logic [23:0] addr_q;
    logic [15:0] len_q;
    logic [1:0]  hi_q;
    logic        hdr_q;
    logic [15:0] poll_cnt_q;
    logic        err_r_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        done_q;
    logic        err_q;

    logic        acc_we;
    logic [31:0] acc_adr;
    logic [7:0]  acc_wdat;
    logic        wb_busy;
    logic        wb_ack;
    logic [7:0]  wb_rdat;
    logic [15:0] poll_inc;

    assign poll_inc = poll_cnt_q + 16'd1;

    // The access each state performs; sampled by the port only when go_q launches it.
    always_comb begin
        acc_we   = 1'b0;
        acc_adr  = BASE_ADR + REG_STAT;
        acc_wdat = 8'h00;
        case (state_q)
            ST_SET_DIV: begin
                acc_we   = 1'b1;
                acc_adr  = BASE_ADR + REG_DIV;
                acc_wdat = DIVISOR;
            end
            ST_CS_ON: begin
                acc_we   = 1'b1;
                acc_adr  = BASE_ADR + REG_CS;
                acc_wdat = CS_ACTIVE;
            end
            ST_TX: begin
                acc_we   = 1'b1;
                acc_adr  = BASE_ADR + REG_DATA;
                acc_wdat = hdr_q ? header_byte(hi_q, addr_q) : 8'h00;
            end
            ST_RX: begin
                acc_adr  = BASE_ADR + REG_DATA;
            end
            ST_CS_OFF: begin
                acc_we   = 1'b1;
                acc_adr  = BASE_ADR + REG_CS;
                acc_wdat = CS_IDLE;
            end
            default: ;
        endcase
    end

    // go_q is raised on entry to an access state and dropped once the port launches it;
    // every transition out of an access state happens on that access's ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            go_q        <= 1'b0;
            addr_q      <= 24'h0;
            len_q       <= 16'h0;
            hi_q        <= 2'd0;
            hdr_q       <= 1'b0;
            poll_cnt_q  <= 16'h0;
            err_r_q     <= 1'b0;
            rd_data_q   <= 8'h0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (go_q && !wb_busy) begin
                go_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        len_q       <= req_len;
                        hi_q        <= 2'd0;
                        hdr_q       <= 1'b1;
                        req_ready_q <= 1'b0;
                        go_q        <= 1'b1;
                        state_q     <= ST_SET_DIV;
                    end
                end
                ST_SET_DIV: begin
                    if (wb_ack) begin
                        go_q    <= 1'b1;
                        state_q <= ST_CS_ON;
                    end
                end
                ST_CS_ON: begin
                    if (wb_ack) begin
                        go_q    <= 1'b1;
                        state_q <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (wb_ack) begin
                        poll_cnt_q <= 16'h0;
                        go_q       <= 1'b1;
                        state_q    <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (wb_ack) begin
                        poll_cnt_q <= poll_inc;
                        go_q       <= 1'b1;
                        if (wb_rdat[0] && poll_inc == POLL_MAX) begin
                            err_r_q <= 1'b1;
                            state_q <= ST_CS_OFF;
                        end else if (wb_rdat[0]) begin
                            state_q <= ST_POLL;
                        end else if (hdr_q) begin
                            if (hi_q == 2'd3) begin
                                hdr_q   <= 1'b0;
                                state_q <= (len_q == 16'h0) ? ST_CS_OFF : ST_TX;
                            end else begin
                                hi_q    <= hi_q + 2'd1;
                                state_q <= ST_TX;
                            end
                        end else begin
                            state_q <= ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (wb_ack) begin
                        rd_data_q  <= wb_rdat;
                        rd_valid_q <= 1'b1;
                        state_q    <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        len_q      <= len_q - 16'd1;
                        go_q       <= 1'b1;
                        state_q    <= (len_q == 16'd1) ? ST_CS_OFF : ST_TX;
                    end
                end
                ST_CS_OFF: begin
                    if (wb_ack) begin
                        done_q  <= 1'b1;
                        err_q   <= err_r_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    err_r_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    wb_master_port u_wb (
        .clk       (clk),
        .reset_n   (reset_n),
        .go_i      (go_q),
        .we_i      (acc_we),
        .adr_i     (acc_adr),
        .wdat_i    (acc_wdat),
        .busy_o    (wb_busy),
        .ack_o     (wb_ack),
        .rdat_o    (wb_rdat),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_ack_i (wbm_ack_i)
    );

    assign req_ready = req_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
